// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes it word by word into instruction memory. The core is held frozen
// until a session completes successfully.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_wready,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  // Capacity in words; a 17-bit compare so N up to 0xFFFF is checked exactly.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t            r_state, w_next;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_idx;       // one extra bit: reaches 2^ADDR_W after the last write
  logic [1:0]        r_byte;
  logic [31:0]       r_word;
  logic [7:0]        r_csum;
  logic [1:0]        r_err_code;

  logic              w_rdy, w_acc, w_start, w_ovf, w_last;
  logic [15:0]       w_len_full;
  logic [ADDR_W:0]   w_idx_inc;

  assign w_acc      = rx_valid && w_rdy;
  assign w_start    = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign w_len_full = {rx_data, r_len[7:0]};
  assign w_ovf      = {1'b0, w_len_full} > CAP;
  assign w_idx_inc  = r_idx + 1'b1;
  assign w_last     = 17'(w_idx_inc) == {1'b0, r_len};

  assign rx_ready   = w_rdy;
  assign imem_waddr = r_idx[ADDR_W-1:0];
  assign imem_wdata = r_word;
  assign err_code   = r_err_code;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next    = r_state;
    w_rdy     = 1'b0;
    imem_we   = 1'b0;
    core_hold = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_LEN_LO;
      S_LEN_LO: begin
        w_rdy = 1'b1;
        if (rx_valid) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_rdy = 1'b1;
        if (rx_valid) begin
          if (w_ovf)                 w_next = S_ERROR;
          else if (w_len_full == '0) w_next = S_CSUM;
          else                       w_next = S_DATA;
        end
      end
      S_DATA: begin
        w_rdy = 1'b1;
        if (rx_valid && r_byte == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        if (imem_wready) w_next = w_last ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        w_rdy = 1'b1;
        if (rx_valid) w_next = (rx_data == r_csum) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
        if (start) w_next = S_LEN_LO;
      end
      S_ERROR: begin
        err = 1'b1;
        if (start) w_next = S_LEN_LO;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, checksum, write index, error code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_idx      <= '0;
      r_byte     <= '0;
      r_word     <= '0;
      r_csum     <= '0;
      r_err_code <= '0;
    end else if (w_start) begin
      r_idx      <= '0;
      r_byte     <= '0;
      r_csum     <= '0;
      r_err_code <= '0;
    end else begin
      case (r_state)
        S_LEN_LO: if (w_acc) r_len[7:0] <= rx_data;
        S_LEN_HI: if (w_acc) begin
          r_len[15:8] <= rx_data;
          if (w_ovf) r_err_code <= 2'b01;
        end
        S_DATA: if (w_acc) begin
          r_word[{r_byte, 3'b000} +: 8] <= rx_data;
          r_csum <= r_csum ^ rx_data;
          r_byte <= r_byte + 2'd1;   // wraps to 0 after the 4th byte
        end
        S_WRITE: if (imem_wready) r_idx <= w_idx_inc;
        S_CSUM: if (w_acc && rx_data != r_csum) r_err_code <= 2'b10;
        default: ;
      endcase
    end
  end

endmodule
